// File: rtl/updown_counter_lim.sv
// Up/down counter with programmable limits, step size, clamped load and saturate/wrap mode.
// Y/Ovf/Err update one edge after the inputs are sampled; there is no backpressure because every enabled edge steps.
module updown_counter_lim #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              EN,
    input  logic              Dir,
    input  logic              Load,
    input  logic [N-1:0]      D,
    input  logic [N-1:0]      Lo,
    input  logic [N-1:0]      Hi,
    input  logic [STEP_W-1:0] Step,
    input  logic              Mode,
    output logic [N-1:0]      Y,
    output logic              AtMax,
    output logic              AtMin,
    output logic              Ovf,
    output logic              Err
);

    logic [N-1:0] r_y;
    logic         r_ovf;
    logic         r_err;

    logic         w_lim_err;
    logic [N:0]   w_step_ext;
    logic [N:0]   w_up_t;
    logic [N:0]   w_dn_t;
    logic         w_out_rng;
    logic [N-1:0] w_y_clamp;
    logic [N-1:0] w_d_clamp;
    logic [N-1:0] w_y_nxt;
    logic         w_ovf_nxt;

    // One extra bit keeps carry out of Hi and borrow below zero visible.
    assign w_lim_err  = (Lo > Hi);
    assign w_step_ext = (N+1)'(Step);
    assign w_up_t     = {1'b0, r_y} + w_step_ext;
    assign w_dn_t     = {1'b0, r_y} - w_step_ext;
    assign w_out_rng  = (r_y < Lo) || (r_y > Hi);
    assign w_y_clamp  = (r_y < Lo) ? Lo : ((r_y > Hi) ? Hi : r_y);
    assign w_d_clamp  = (D < Lo) ? Lo : ((D > Hi) ? Hi : D);

    always_comb begin
        w_y_nxt   = r_y;
        w_ovf_nxt = 1'b0;
        if (w_lim_err) begin
            w_y_nxt = r_y;
        end else if (Load) begin
            w_y_nxt = w_d_clamp;
        end else if (EN) begin
            if (w_out_rng) begin
                // Re-enter the window silently after limits moved under Y.
                w_y_nxt = w_y_clamp;
            end else if (Dir) begin
                if (w_up_t > {1'b0, Hi}) begin
                    if (Mode) begin
                        w_y_nxt   = Lo;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_y_nxt   = Hi;
                        w_ovf_nxt = (r_y != Hi);
                    end
                end else begin
                    w_y_nxt = w_up_t[N-1:0];
                end
            end else begin
                if (w_dn_t[N] || (w_dn_t < {1'b0, Lo})) begin
                    if (Mode) begin
                        w_y_nxt   = Hi;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_y_nxt   = Lo;
                        w_ovf_nxt = (r_y != Lo);
                    end
                end else begin
                    w_y_nxt = w_dn_t[N-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_y   <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_y   <= w_y_nxt;
            r_ovf <= w_ovf_nxt;
            r_err <= w_lim_err;
        end
    end

    assign Y     = r_y;
    assign Ovf   = r_ovf;
    assign Err   = r_err;
    assign AtMax = (r_y == Hi);
    assign AtMin = (r_y == Lo);

endmodule

// File: tb/tb_updown_counter_lim.sv
// Directed bench for updown_counter_lim: expected responses queued per edge, checked by a monitor.
module tb_updown_counter_lim;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       en;
    logic       dir;
    logic       load;
    logic [7:0] d;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] step;
    logic       mode;
    logic [7:0] y;
    logic       at_max;
    logic       at_min;
    logic       ovf;
    logic       err;

    typedef struct packed {
        logic [7:0] y;
        logic       ovf;
        logic       err;
        logic       at_max;
        logic       at_min;
    } exp_t;

    exp_t  q_exp[$];
    string q_nm[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    stim_done = 1'b0;

    updown_counter_lim #(.N(8), .STEP_W(4)) dut (
        .CLK    (clk),
        .N_RESET(n_reset),
        .EN     (en),
        .Dir    (dir),
        .Load   (load),
        .D      (d),
        .Lo     (lo),
        .Hi     (hi),
        .Step   (step),
        .Mode   (mode),
        .Y      (y),
        .AtMax  (at_max),
        .AtMin  (at_min),
        .Ovf    (ovf),
        .Err    (err)
    );

    always #5 clk = ~clk;

    // Inputs are already set at the negedge; queue what the next posedge must produce.
    task automatic cyc(input logic [7:0] ey, input logic eovf, input logic eerr, input string nm);
        exp_t e;
        e.y      = ey;
        e.ovf    = eovf;
        e.err    = eerr;
        e.at_max = (ey == hi);
        e.at_min = (ey == lo);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_nm.pop_front();
                chk1(nm, "Y",     y,             e.y);
                chk1(nm, "Ovf",   {7'b0, ovf},    {7'b0, e.ovf});
                chk1(nm, "Err",   {7'b0, err},    {7'b0, e.err});
                chk1(nm, "AtMax", {7'b0, at_max}, {7'b0, e.at_max});
                chk1(nm, "AtMin", {7'b0, at_min}, {7'b0, e.at_min});
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus not complete, expected completion");
            $fatal(1, "timeout");
        end
    end

    initial begin : stim
        n_reset = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b1; d = 8'd50;
        lo = 8'd0; hi = 8'd255; step = 4'd1; mode = 1'b0;
        @(negedge clk);
        cyc(8'd0, 1'b0, 1'b0, "reset");

        // reset mid-count overrides EN and Load
        n_reset = 1'b1; load = 1'b0;
        cyc(8'd1, 1'b0, 1'b0, "count1");
        cyc(8'd2, 1'b0, 1'b0, "count2");
        n_reset = 1'b0; load = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, "reset_mid");
        n_reset = 1'b1;

        // saturate from 10 in [10,20] step 3
        lo = 8'd10; hi = 8'd20; step = 4'd3; d = 8'd10; load = 1'b1;
        cyc(8'd10, 1'b0, 1'b0, "sat_load");
        load = 1'b0;
        cyc(8'd13, 1'b0, 1'b0, "sat13");
        cyc(8'd16, 1'b0, 1'b0, "sat16");
        cyc(8'd19, 1'b0, 1'b0, "sat19");
        cyc(8'd20, 1'b1, 1'b0, "sat_hit");
        cyc(8'd20, 1'b0, 1'b0, "sat_pinned");

        // wrap mode
        mode = 1'b1; load = 1'b1; d = 8'd10;
        cyc(8'd10, 1'b0, 1'b0, "wrap_load");
        load = 1'b0;
        cyc(8'd13, 1'b0, 1'b0, "wrap13");
        cyc(8'd16, 1'b0, 1'b0, "wrap16");
        cyc(8'd19, 1'b0, 1'b0, "wrap19");
        cyc(8'd10, 1'b1, 1'b0, "wrap_hi");
        cyc(8'd13, 1'b0, 1'b0, "wrap_again");
        load = 1'b1; d = 8'd11;
        cyc(8'd11, 1'b0, 1'b0, "wrap_load11");
        load = 1'b0; dir = 1'b0;
        cyc(8'd20, 1'b1, 1'b0, "wrap_lo");

        // landing exactly on Hi is not an event
        mode = 1'b0; dir = 1'b1; step = 4'd5; load = 1'b1; d = 8'd10;
        cyc(8'd10, 1'b0, 1'b0, "land_load");
        load = 1'b0;
        cyc(8'd15, 1'b0, 1'b0, "land15");
        cyc(8'd20, 1'b0, 1'b0, "land_hi");

        // borrow below zero
        lo = 8'd0; hi = 8'd255; step = 4'd15; dir = 1'b0; load = 1'b1; d = 8'd5;
        cyc(8'd5, 1'b0, 1'b0, "borrow_load");
        load = 1'b0;
        cyc(8'd0, 1'b1, 1'b0, "borrow");
        cyc(8'd0, 1'b0, 1'b0, "borrow_pinned");

        // clamped load, load beats EN
        lo = 8'd10; hi = 8'd20; load = 1'b1; en = 1'b0; d = 8'd250;
        cyc(8'd20, 1'b0, 1'b0, "load_clamp_hi");
        en = 1'b1; dir = 1'b1; step = 4'd3; d = 8'd3;
        cyc(8'd10, 1'b0, 1'b0, "load_clamp_lo");
        d = 8'd15;
        cyc(8'd15, 1'b0, 1'b0, "load_wins");

        // Lo > Hi freezes Y even against Load
        lo = 8'd30; d = 8'd25;
        cyc(8'd15, 1'b0, 1'b1, "err_set");
        load = 1'b0;
        cyc(8'd15, 1'b0, 1'b1, "err_hold");
        lo = 8'd10;
        cyc(8'd18, 1'b0, 1'b0, "err_clear");

        // limits moved under Y: clamp first, no pulse
        lo = 8'd0; hi = 8'd12;
        cyc(8'd12, 1'b0, 1'b0, "oor_clamp");
        cyc(8'd12, 1'b0, 1'b0, "oor_pinned");
        mode = 1'b1;
        cyc(8'd0, 1'b1, 1'b0, "oor_wrap");

        // Lo == Hi
        lo = 8'd7; hi = 8'd7;
        cyc(8'd7, 1'b0, 1'b0, "eq_clamp");
        step = 4'd1;
        cyc(8'd7, 1'b1, 1'b0, "eq_up");
        dir = 1'b0;
        cyc(8'd7, 1'b1, 1'b0, "eq_dn");
        en = 1'b0;
        cyc(8'd7, 1'b0, 1'b0, "en_off");

        // step 0 and full-range behaviour
        lo = 8'd0; hi = 8'd255; en = 1'b1; step = 4'd0; mode = 1'b0;
        cyc(8'd7, 1'b0, 1'b0, "step0");
        step = 4'd1; dir = 1'b1; load = 1'b1; d = 8'd254;
        cyc(8'd254, 1'b0, 1'b0, "full_load");
        load = 1'b0;
        cyc(8'd255, 1'b0, 1'b0, "full_255");
        cyc(8'd255, 1'b0, 1'b0, "full_sat");
        mode = 1'b1;
        cyc(8'd0, 1'b1, 1'b0, "full_wrap");
        mode = 1'b0; dir = 1'b0;
        cyc(8'd0, 1'b0, 1'b0, "full_sat_lo");

        @(posedge clk);
        #2;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
